// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-register stage.
//   state_t : control FSM encoding (EMPTY / HOLD / FULL)
//   OCC_W   : width of the occupancy output
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HOLD  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_skid_reg_load_register.sv
// N-bit data register used for the main and skid entries of pipe_skid_reg.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, loads RST_VAL
//   clr  : synchronous clear to RST_VAL (wins over load)
//   load : synchronous load enable for d
//   d    : data in
//   q    : registered data out
module load_register #(
    parameter int             N       = 32,
    parameter logic [N-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry,
// synchronous flush with NOP injection and an occupancy output.
//
// Handshake: a beat moves on a port in any cycle where valid and ready are
// both high at the rising clock edge; valid never depends on ready, and
// once out_valid is raised the presented beat stays until it is taken or
// flushed.
//
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous squash of all held beats (beats leaving the
//                stage in the same cycle still complete downstream)
//   in_valid / in_ready / in_data    : upstream side
//   out_valid / out_ready / out_data : downstream side
//   occ        : number of held beats (0..2)
//   dbg_state  : current control state, for observation only
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int           N         = 32,
    parameter logic [N-1:0] NOP_VALUE = '0,
    parameter bit           SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [OCC_W-1:0] occ,
    output logic [1:0]       dbg_state
);

    state_t         state_q, state_d;
    logic           in_xfer, out_xfer;
    logic           main_load, main_clr, skid_load, skid_clr;
    logic [N-1:0]   main_d, main_q, skid_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_d    = in_data;
        if (flush) begin
            // Anything accepted this cycle is dropped; the presented beat
            // has already been handed downstream if out_ready was high.
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        main_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end else if (in_xfer && SKID) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        skid_clr  = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    load_register #(.N(N), .RST_VAL(NOP_VALUE)) u_main (
        .clk  (clk),
        .rst  (rst),
        .clr  (main_clr),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    load_register #(.N(N), .RST_VAL(NOP_VALUE)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (skid_clr),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

    generate
        if (SKID) begin : g_skid
            // Registered ready: looks at the next state so the upstream
            // side never sees a path from out_ready.
            logic rdy_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_d != ST_FULL);
                end
            end
            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occ       = {state_q == ST_FULL, state_q == ST_HOLD};
    assign dbg_state = state_q;

endmodule
